// File: rtl/mapper_latch_port_rom_pkg.sv
// Shared definitions for the latch-port ROM mapper: access FSM states and
// the fixed window/data constants.
package mapper_latch_port_rom_pkg;

  // Single-outstanding access sequencer states
  typedef enum logic [1:0] {
    MAP_IDLE = 2'd0,
    MAP_REQ  = 2'd1,
    MAP_DONE = 2'd2
  } map_acc_state_t;

  // Offset bits inside one 16 KB CPU page
  localparam int MAP_PAGE_BITS = 14;

  // Value presented on cpu_data whenever no read result is being held
  localparam logic [7:0] MAP_DATA_IDLE = 8'hFF;

endpackage : mapper_latch_port_rom_pkg

// File: rtl/mapper_acc_timer.sv
// Access timeout counter: cleared while the mapper is idle, counts every
// cycle spent waiting for memory, and flags the last allowed cycle.
module mapper_acc_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: the cycle in which an unanswered request is abandoned
  assign tc = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule : mapper_acc_timer

// File: rtl/mapper_latch_port_rom.sv
// Latch-port ROM mapper: maps CPU reads in one 16 KB window onto external
// ROM space using the bank byte from the latch-port stage. One access is in
// flight at a time; the CPU is stalled until memory answers or the timer
// expires. Bank updates are only committed while idle. BANK_BITS must be
// at most 8 since the bank is taken from the low bits of the latch byte.
module mapper_latch_port_rom
  import mapper_latch_port_rom_pkg::*;
#(
  parameter int         BANK_BITS   = 8,
  parameter logic [1:0] WIN_PAGE    = 2'd2,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               en,
  input  logic [7:0]                         data_to_mapper,
  input  logic [BANK_BITS-1:0]               rom_mask,
  input  logic [15:0]                        cpu_addr,
  input  logic                               cpu_req,
  input  logic                               cpu_mreq,
  input  logic                               cpu_rd,
  output logic [7:0]                         cpu_data,
  output logic                               cpu_wait,
  output logic [BANK_BITS+MAP_PAGE_BITS-1:0] mem_addr,
  output logic                               mem_rd,
  input  logic                               mem_ack,
  input  logic [7:0]                         mem_data,
  output logic [BANK_BITS-1:0]               bank_cur,
  output logic                               timeout_err
);

  localparam int ADDR_W = BANK_BITS + MAP_PAGE_BITS;

  map_acc_state_t      state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                cpu_wait_q, cpu_wait_d;
  logic [7:0]          cpu_data_q, cpu_data_d;
  logic [BANK_BITS-1:0] bank_cur_q, bank_cur_d;
  logic                timeout_err_q, timeout_err_d;

  logic hit;
  logic timer_clr;
  logic timer_inc;
  logic timer_tc;

  // Read strobe into the mapped window while this slot is selected;
  // writes and IO cycles never start an access
  assign hit = cpu_req & cpu_mreq & cpu_rd & en &
               (cpu_addr[15:MAP_PAGE_BITS] == WIN_PAGE);

  // Timer is held at zero while idle so every access starts from a fresh count
  assign timer_clr = (state_q == MAP_IDLE);
  assign timer_inc = (state_q == MAP_REQ);

  mapper_acc_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .tc      (timer_tc)
  );

  // Access FSM next state, bank commit and address/data register updates
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = mem_rd_q;
    cpu_wait_d    = cpu_wait_q;
    cpu_data_d    = cpu_data_q;
    bank_cur_d    = bank_cur_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      MAP_IDLE: begin
        // The latch is tracked only here; during an access the bank is frozen
        bank_cur_d = data_to_mapper[BANK_BITS-1:0] & rom_mask;
        if (hit) begin
          state_d    = MAP_REQ;
          mem_addr_d = {bank_cur_q, cpu_addr[MAP_PAGE_BITS-1:0]};
          mem_rd_d   = 1'b1;
          cpu_wait_d = 1'b1;
        end
      end

      MAP_REQ: begin
        // An ack arriving on the terminal cycle still delivers its data
        if (mem_ack) begin
          state_d    = MAP_DONE;
          cpu_data_d = mem_data;
          mem_rd_d   = 1'b0;
          cpu_wait_d = 1'b0;
        end else if (timer_tc) begin
          state_d       = MAP_DONE;
          cpu_data_d    = MAP_DATA_IDLE;
          mem_rd_d      = 1'b0;
          cpu_wait_d    = 1'b0;
          timeout_err_d = 1'b1;
        end
      end

      MAP_DONE: begin
        // Hold the result until the CPU ends its read cycle
        if (!cpu_rd) begin
          state_d    = MAP_IDLE;
          cpu_data_d = MAP_DATA_IDLE;
        end
      end

      default: begin
        state_d    = MAP_IDLE;
        mem_rd_d   = 1'b0;
        cpu_wait_d = 1'b0;
        cpu_data_d = MAP_DATA_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= MAP_IDLE;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      cpu_wait_q    <= 1'b0;
      cpu_data_q    <= MAP_DATA_IDLE;
      bank_cur_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      cpu_wait_q    <= cpu_wait_d;
      cpu_data_q    <= cpu_data_d;
      bank_cur_q    <= bank_cur_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cpu_data    = cpu_data_q;
  assign cpu_wait    = cpu_wait_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign bank_cur    = bank_cur_q;
  assign timeout_err = timeout_err_q;

endmodule : mapper_latch_port_rom

// File: tb/tb_mapper_latch_port_rom.sv
// Bench for the latch-port ROM mapper. Two instances share all inputs
// except the access strobe and memory ack: dut_a uses the default timeout,
// dut_b a 4-cycle timeout for the abort cases.
module tb_mapper_latch_port_rom;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [7:0]  data_to_mapper;
  logic [7:0]  rom_mask;
  logic [15:0] cpu_addr;
  logic        cpu_req_a, cpu_req_b;
  logic        cpu_mreq;
  logic        cpu_rd;
  logic        mem_ack_a, mem_ack_b;
  logic [7:0]  mem_data;

  logic [7:0]  cpu_data_a, cpu_data_b;
  logic        cpu_wait_a, cpu_wait_b;
  logic [21:0] mem_addr_a, mem_addr_b;
  logic        mem_rd_a, mem_rd_b;
  logic [7:0]  bank_cur_a, bank_cur_b;
  logic        timeout_err_a, timeout_err_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    int          waits;
    logic        to;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mapper_latch_port_rom dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .data_to_mapper (data_to_mapper),
    .rom_mask       (rom_mask),
    .cpu_addr       (cpu_addr),
    .cpu_req        (cpu_req_a),
    .cpu_mreq       (cpu_mreq),
    .cpu_rd         (cpu_rd),
    .cpu_data       (cpu_data_a),
    .cpu_wait       (cpu_wait_a),
    .mem_addr       (mem_addr_a),
    .mem_rd         (mem_rd_a),
    .mem_ack        (mem_ack_a),
    .mem_data       (mem_data),
    .bank_cur       (bank_cur_a),
    .timeout_err    (timeout_err_a)
  );

  mapper_latch_port_rom #(.TIMEOUT_CYC(4)) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .data_to_mapper (data_to_mapper),
    .rom_mask       (rom_mask),
    .cpu_addr       (cpu_addr),
    .cpu_req        (cpu_req_b),
    .cpu_mreq       (cpu_mreq),
    .cpu_rd         (cpu_rd),
    .cpu_data       (cpu_data_b),
    .cpu_wait       (cpu_wait_b),
    .mem_addr       (mem_addr_b),
    .mem_rd         (mem_rd_b),
    .mem_ack        (mem_ack_b),
    .mem_data       (mem_data),
    .bank_cur       (bank_cur_b),
    .timeout_err    (timeout_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic g_wait(input bit b);
    return b ? cpu_wait_b : cpu_wait_a;
  endfunction
  function automatic logic g_rd(input bit b);
    return b ? mem_rd_b : mem_rd_a;
  endfunction
  function automatic logic [7:0] g_data(input bit b);
    return b ? cpu_data_b : cpu_data_a;
  endfunction
  function automatic logic [21:0] g_addr(input bit b);
    return b ? mem_addr_b : mem_addr_a;
  endfunction
  function automatic logic g_err(input bit b);
    return b ? timeout_err_b : timeout_err_a;
  endfunction

  task automatic set_ack(input bit b, input logic v);
    if (b) mem_ack_b = v;
    else   mem_ack_a = v;
  endtask

  // One read access: ack_after = sample edge (counted from the hit) carrying
  // mem_ack, 0 = never; new_dtm >= 0 changes the latch byte mid-access.
  task automatic run_read(input bit use_b, input logic [15:0] addr, input int ack_after,
                          input logic [7:0] ack_data, input int new_dtm,
                          input logic [21:0] exp_addr, input logic [7:0] exp_data,
                          input int exp_waits, input logic exp_to);
    exp_t e;
    int   k;
    bit   done;
    e.addr = exp_addr; e.data = exp_data; e.waits = exp_waits; e.to = exp_to;
    sb.push_back(e);

    cpu_addr = addr; cpu_mreq = 1'b1; cpu_rd = 1'b1; en = 1'b1;
    if (use_b) cpu_req_b = 1'b1;
    else       cpu_req_a = 1'b1;
    tick();
    cpu_req_a = 1'b0; cpu_req_b = 1'b0;
    // slot deselect and address change must not cancel the access
    en = 1'b0; cpu_addr = 16'h0000;
    check("rd_start", 32'(g_rd(use_b)), 32'd1);
    check("wait_start", 32'(g_wait(use_b)), 32'd1);

    k = 0; done = 1'b0;
    while (!done && k < 300) begin
      k++;
      if (k == ack_after) begin
        set_ack(use_b, 1'b1);
        mem_data = ack_data;
      end
      if (k == 2 && new_dtm >= 0) data_to_mapper = 8'(new_dtm);
      tick();
      set_ack(use_b, 1'b0);
      if (g_wait(use_b) == 1'b0) done = 1'b1;
      else if (g_rd(use_b) !== 1'b1) check("rd_hold", 32'(g_rd(use_b)), 32'd1);
    end
    if (!done) check("wait_bound", 32'd0, 32'd1);

    e = sb.pop_front();
    check("mem_addr", 32'(g_addr(use_b)), 32'(e.addr));
    check("wait_cycles", 32'(k), 32'(e.waits));
    check("cpu_data", 32'(g_data(use_b)), 32'(e.data));
    check("rd_end", 32'(g_rd(use_b)), 32'd0);
    check("timeout_err", 32'(g_err(use_b)), 32'(e.to));
    $display("txn %s addr=%h mem_addr=%h waits=%0d data=%h to=%0d",
             use_b ? "B" : "A", addr, g_addr(use_b), k, g_data(use_b), g_err(use_b));

    // late ack while the result is held must be ignored
    set_ack(use_b, 1'b1);
    mem_data = 8'h5A;
    tick();
    set_ack(use_b, 1'b0);
    check("stale_ack_data", 32'(g_data(use_b)), 32'(e.data));
    check("stale_ack_wait", 32'(g_wait(use_b)), 32'd0);

    cpu_rd = 1'b0; cpu_mreq = 1'b0;
    tick();
    check("idle_data", 32'(g_data(use_b)), 32'hFF);
  endtask

  task automatic nohit(input string tag, input logic [15:0] addr, input logic mreq,
                       input logic rd, input logic en_v);
    cpu_addr = addr; cpu_mreq = mreq; cpu_rd = rd; en = en_v; cpu_req_a = 1'b1;
    tick();
    cpu_req_a = 1'b0;
    check({tag, "_rd"}, 32'(mem_rd_a), 32'd0);
    check({tag, "_wait"}, 32'(cpu_wait_a), 32'd0);
    tick();
    check({tag, "_rd2"}, 32'(mem_rd_a), 32'd0);
    $display("txn A nohit %s addr=%h mreq=%0d rd=%0d en=%0d mem_rd=%0d",
             tag, addr, mreq, rd, en_v, mem_rd_a);
    cpu_rd = 1'b0; cpu_mreq = 1'b0; en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; data_to_mapper = 8'h05; rom_mask = 8'h0F;
    cpu_addr = 16'h0000; cpu_req_a = 1'b0; cpu_req_b = 1'b0; cpu_mreq = 1'b0;
    cpu_rd = 1'b0; mem_ack_a = 1'b0; mem_ack_b = 1'b0; mem_data = 8'h00;
    tick(); tick();

    // reset state (bank must not commit while reset is held)
    check("rst_data", 32'(cpu_data_a), 32'hFF);
    check("rst_rd", 32'(mem_rd_a), 32'd0);
    check("rst_wait", 32'(cpu_wait_a), 32'd0);
    check("rst_addr", 32'(mem_addr_a), 32'd0);
    check("rst_bank", 32'(bank_cur_a), 32'd0);
    check("rst_err", 32'(timeout_err_b), 32'd0);

    reset_n = 1'b1;
    tick();
    check("bank_commit", 32'(bank_cur_a), 32'h05);

    // basic read: bank 5, ack on the 4th waiting cycle
    run_read(1'b0, 16'h8123, 4, 8'hA5, -1, 22'h014123, 8'hA5, 4, 1'b0);
    check("bank_after_basic", 32'(bank_cur_a), 32'h05);

    // mask wrap: 0x13 & 0x0F = 3
    data_to_mapper = 8'h13;
    tick();
    check("bank_mask", 32'(bank_cur_a), 32'h03);
    run_read(1'b0, 16'hA000, 2, 8'h11, -1, 22'h00E000, 8'h11, 2, 1'b0);

    // deferred bank change during an access
    data_to_mapper = 8'h02;
    tick();
    check("bank_pre_defer", 32'(bank_cur_a), 32'h02);
    run_read(1'b0, 16'h8004, 3, 8'h42, 7, 22'h008004, 8'h42, 3, 1'b0);
    check("bank_first_idle", 32'(bank_cur_a), 32'h02);
    tick();
    check("bank_deferred", 32'(bank_cur_a), 32'h07);

    // ack on the terminal timer cycle wins over timeout
    run_read(1'b1, 16'hBFFF, 4, 8'h3C, -1, 22'h01FFFF, 8'h3C, 4, 1'b0);

    // timeout with no ack
    run_read(1'b1, 16'h8000, 0, 8'h00, -1, 22'h01C000, 8'hFF, 4, 1'b1);
    mem_ack_b = 1'b1; mem_data = 8'h77;
    tick();
    mem_ack_b = 1'b0;
    check("late_ack_data", 32'(cpu_data_b), 32'hFF);
    check("late_ack_rd", 32'(mem_rd_b), 32'd0);
    check("err_sticky", 32'(timeout_err_b), 32'd1);

    // strobes that must not start an access
    nohit("page1",  16'h4000, 1'b1, 1'b1, 1'b1);
    nohit("write",  16'h8000, 1'b1, 1'b0, 1'b1);
    nohit("io",     16'h8000, 1'b0, 1'b1, 1'b1);
    nohit("en_off", 16'h8000, 1'b1, 1'b1, 1'b0);

    // reset in the middle of an access
    cpu_addr = 16'h8010; cpu_mreq = 1'b1; cpu_rd = 1'b1; en = 1'b1; cpu_req_a = 1'b1;
    tick();
    cpu_req_a = 1'b0;
    tick();
    check("mid_rd", 32'(mem_rd_a), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mrst_rd", 32'(mem_rd_a), 32'd0);
    check("mrst_wait", 32'(cpu_wait_a), 32'd0);
    check("mrst_data", 32'(cpu_data_a), 32'hFF);
    check("mrst_addr", 32'(mem_addr_a), 32'd0);
    check("mrst_err", 32'(timeout_err_b), 32'd0);
    $display("txn A reset mid-access mem_rd=%0d cpu_wait=%0d cpu_data=%h",
             mem_rd_a, cpu_wait_a, cpu_data_a);
    reset_n = 1'b1; cpu_rd = 1'b0; cpu_mreq = 1'b0; en = 1'b0;
    tick(); tick();
    check("post_rst_rd", 32'(mem_rd_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mapper_latch_port_rom
